// File: rtl/mac_seq_pkg.sv
// rtl/mac_seq_pkg.sv - shared types and widths for the MAC dot-product sequencer
package mac_seq_pkg;

  localparam int ACT_W     = 16;
  localparam int ACC_W     = 24;
  localparam int DEF_LEN_W = 16;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    RUN  = 3'd2,
    WAIT = 3'd3,
    DONE = 3'd4
  } state_t;

endpackage

// File: rtl/mac_dot_sequencer.sv
// rtl/mac_dot_sequencer.sv - dot-product job sequencer driving an external saturating MAC (option: MAC_ZERO_SKIP_EN)
module mac_dot_sequencer
  import mac_seq_pkg::*;
#(
  parameter int LEN_W = DEF_LEN_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic [ACC_W-1:0] bias,
  output logic             busy,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [ACT_W-1:0] op_a,
  input  logic [ACT_W-1:0] op_w,
  output logic [ACT_W-1:0] mac_a,
  output logic [ACT_W-1:0] mac_w,
  output logic [ACC_W-1:0] mac_t,
  input  logic [ACC_W-1:0] mac_y,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [ACC_W-1:0] res_data
`ifdef MAC_ZERO_SKIP_EN
  ,
  output logic [LEN_W-1:0] skip_cnt
`endif
);

  state_t           state;
  logic [LEN_W-1:0] rem;
  logic [ACC_W-1:0] bias_q;
  logic             fire;

  assign fire      = op_valid && (state == RUN);
  assign busy      = (state != IDLE);
  assign op_ready  = (state == RUN);
  assign res_valid = (state == DONE);

  // Job FSM: latch job, seed MAC with bias, count pairs, capture the final sum
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rem      <= '0;
      bias_q   <= '0;
      res_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            rem    <= len;
            bias_q <= bias;
            state  <= LOAD;
          end
        end
        LOAD: state <= (rem != '0) ? RUN : WAIT;
        RUN: begin
          if (fire) begin
            rem <= rem - LEN_W'(1);
            if (rem == LEN_W'(1)) state <= WAIT;
          end
        end
        WAIT: begin
          // Last accumulate landed in the MAC output register on the previous edge
          res_data <= mac_y;
          state    <= DONE;
        end
        DONE: if (res_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MAC_ZERO_SKIP_EN
  logic [ACT_W-1:0] held_w;
  logic             zero_op;

  assign zero_op = (op_a == '0) || (op_w == '0);

  // Operand isolation: remember the last live weight and count skipped products
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      held_w   <= '0;
      skip_cnt <= '0;
    end else begin
      if (state == IDLE && start) skip_cnt <= '0;
      else if (fire && zero_op)   skip_cnt <= skip_cnt + LEN_W'(1);
      if (fire && !zero_op) held_w <= op_w;
    end
  end
`endif

  // MAC operand mux: recirculate Y as addend except when seeding with bias
  always_comb begin
    mac_a = '0;
    mac_w = '0;
    mac_t = mac_y;
    case (state)
      LOAD: mac_t = bias_q;
      RUN: begin
`ifdef MAC_ZERO_SKIP_EN
        mac_w = held_w;
        if (fire && !zero_op) begin
          mac_a = op_a;
          mac_w = op_w;
        end
`else
        if (fire) begin
          mac_a = op_a;
          mac_w = op_w;
        end
`endif
      end
      WAIT, DONE: begin
`ifdef MAC_ZERO_SKIP_EN
        mac_w = held_w;
`endif
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mac_dot_sequencer.sv
// tb/tb_mac_dot_sequencer.sv - randomized self-checking bench with a behavioural MAC and job-level reference model
module tb_mac_dot_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] len;
  logic [23:0] bias;
  logic        busy;
  logic        op_valid;
  logic        op_ready;
  logic [15:0] op_a;
  logic [15:0] op_w;
  logic [15:0] mac_a;
  logic [15:0] mac_w;
  logic [23:0] mac_t;
  logic [23:0] mac_y;
  logic        res_valid;
  logic        res_ready;
  logic [23:0] res_data;
`ifdef MAC_ZERO_SKIP_EN
  logic [15:0] skip_cnt;
`endif

  mac_dot_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len), .bias(bias), .busy(busy),
    .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_w(op_w),
    .mac_a(mac_a), .mac_w(mac_w), .mac_t(mac_t), .mac_y(mac_y),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data)
`ifdef MAC_ZERO_SKIP_EN
    , .skip_cnt(skip_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] sat24(input longint v);
    if (v > 64'sd8388607) return 24'h7FFFFF;
    if (v < -64'sd8388608) return 24'h800000;
    return v[23:0];
  endfunction

  // Behavioural MAC PE: Y <= sat(A*W + T), registered, cleared by reset
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) mac_y <= '0;
    else mac_y <= sat24(longint'($signed(mac_a)) * longint'($signed(mac_w)) + longint'($signed(mac_t)));
  end

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int vld_cyc = -1;
  logic seen_vld = 1'b0;
  logic check_en = 1'b0;

  logic               exp_busy, exp_rdy, exp_vld;
  logic [23:0]        exp_res, exp_t;
  logic [15:0]        exp_a, exp_w, held_w;
  logic signed [23:0] exp_acc;
  int                 exp_skip;
  logic [15:0]        pa [64];
  logic [15:0]        pw [64];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at t=%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Per-cycle comparison of every DUT output against the model's expectation
  always @(negedge clk) begin
    if (check_en) begin
      check("busy", 32'(busy), 32'(exp_busy));
      check("op_ready", 32'(op_ready), 32'(exp_rdy));
      check("res_valid", 32'(res_valid), 32'(exp_vld));
      check("res_data", 32'(res_data), 32'(exp_res));
      check("mac_a", 32'(mac_a), 32'(exp_a));
      check("mac_w", 32'(mac_w), 32'(exp_w));
      check("mac_t", 32'(mac_t), 32'(exp_t));
`ifdef MAC_ZERO_SKIP_EN
      check("skip_cnt", 32'(skip_cnt), 32'(exp_skip));
`endif
      if (res_valid && !seen_vld) begin
        seen_vld = 1'b1;
        vld_cyc  = cyc;
      end
    end
  end

  function automatic logic [15:0] idle_w();
`ifdef MAC_ZERO_SKIP_EN
    return held_w;
`else
    return 16'h0;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic clear_model();
    exp_busy = 0; exp_rdy = 0; exp_vld = 0;
    exp_res = '0; exp_t = '0; exp_a = '0; exp_w = '0;
    held_w = '0; exp_acc = '0; exp_skip = 0;
  endtask

  // One job: n pairs from pa/pw; bmode 0=back-to-back 1=alternate bubbles 2=random; abort>=0 resets after that many pairs
  task automatic run_job(input int n, input logic [23:0] b, input int bmode, input int hold, input int abort);
    int   sent;
    int   k;
    logic v;
    logic z;
    seen_vld = 1'b0;
    vld_cyc  = -1;
    cyc      = 0;
    start = 1; len = 16'(n); bias = b;
    exp_busy = 0; exp_rdy = 0; exp_vld = 0; exp_a = '0; exp_w = '0; exp_t = exp_acc;
    step();
    start = 0; len = 16'($urandom); bias = 24'($urandom);
    exp_busy = 1; exp_t = b; exp_skip = 0;
    step();
    exp_acc = b;
    sent = 0;
    k = 0;
    while (sent < n) begin
      if (sent == abort) begin
        check_en = 0;
        rst_n = 0;
        #2;
        check("rst_busy", 32'(busy), 0);
        check("rst_op_ready", 32'(op_ready), 0);
        check("rst_res_valid", 32'(res_valid), 0);
        check("rst_res_data", 32'(res_data), 0);
        check("rst_mac_a", 32'(mac_a), 0);
        check("rst_mac_w", 32'(mac_w), 0);
        check("rst_mac_t", 32'(mac_t), 0);
        op_valid = 0;
        step();
        step();
        rst_n = 1;
        clear_model();
        check_en = 1;
        for (int i = 0; i < 4; i++) step();
        return;
      end
      case (bmode)
        0: v = 1'b1;
        1: v = (k % 2 == 0);
        default: v = ($urandom_range(0, 2) != 0);
      endcase
      k++;
      op_valid = v;
      op_a = v ? pa[sent] : 16'($urandom);
      op_w = v ? pw[sent] : 16'($urandom);
      exp_rdy = 1;
      exp_t = exp_acc;
      z = (op_a == 0) || (op_w == 0);
`ifdef MAC_ZERO_SKIP_EN
      exp_a = (v && !z) ? op_a : 16'h0;
      exp_w = (v && !z) ? op_w : held_w;
`else
      exp_a = v ? op_a : 16'h0;
      exp_w = v ? op_w : 16'h0;
`endif
      step();
      if (v) begin
        exp_acc = sat24(longint'(exp_acc) + longint'($signed(op_a)) * longint'($signed(op_w)));
        if (z) exp_skip++;
        else held_w = op_w;
        sent++;
      end
    end
    op_valid = 1'($urandom);
    op_a = 16'($urandom);
    op_w = 16'($urandom);
    exp_rdy = 0; exp_a = '0; exp_w = idle_w(); exp_t = exp_acc;
    step();
    op_valid = 0;
    exp_res = exp_acc;
    exp_vld = 1;
    for (int i = 0; i < hold; i++) begin
      res_ready = 0;
      start = 1'($urandom);
      step();
    end
    res_ready = 1;
    start = 0;
    step();
    res_ready = 0;
    exp_busy = 0; exp_vld = 0; exp_a = '0; exp_w = '0; exp_t = exp_acc;
  endtask

  initial begin
    rst_n = 0; start = 0; len = '0; bias = '0; op_valid = 0; op_a = '0; op_w = '0; res_ready = 0;
    clear_model();
    #12;
    check("reset_busy", 32'(busy), 0);
    check("reset_op_ready", 32'(op_ready), 0);
    check("reset_res_valid", 32'(res_valid), 0);
    check("reset_res_data", 32'(res_data), 0);
    check("reset_mac_t", 32'(mac_t), 0);
    @(posedge clk);
    #1;
    rst_n = 1;
    check_en = 1;
    step();

    // Basic accumulation: 10 + 6 + 20 - 7 = 29, result at cycle 6
    pa[0] = 16'd2; pw[0] = 16'd3; pa[1] = 16'd4; pw[1] = 16'd5; pa[2] = 16'hFFFF; pw[2] = 16'd7;
    run_job(3, 24'd10, 0, 0, -1);
    check("basic_model", 32'(exp_res), 32'd29);
    check("basic_res", 32'(res_data), 32'd29);
    check("basic_cycle", 32'(vld_cyc), 32'd6);

    // Empty job returns bias
    run_job(0, 24'hFFFFFB, 0, 1, -1);
    check("empty_res", 32'(res_data), 32'h00FFFFFB);
    check("empty_cycle", 32'(vld_cyc), 32'd3);

    // Alternate bubbles delay by two cycles
    pa[0] = 16'd2; pw[0] = 16'd3; pa[1] = 16'd4; pw[1] = 16'd5; pa[2] = 16'hFFFF; pw[2] = 16'd7;
    run_job(3, 24'd10, 1, 0, -1);
    check("bubble_res", 32'(res_data), 32'd29);
    check("bubble_cycle", 32'(vld_cyc), 32'd8);

    // Saturation is per step: clip to max, then subtract one
    pa[0] = 16'd100; pw[0] = 16'd100; pa[1] = 16'hFFFF; pw[1] = 16'd1;
    run_job(2, 24'd8388600, 0, 0, -1);
    check("sat_model", 32'(exp_res), 32'd8388606);
    check("sat_res", 32'(res_data), 32'd8388606);
    check("sat_cycle", 32'(vld_cyc), 32'd5);

    // Backpressure with start pulses while the result is held
    pa[0] = 16'd2; pw[0] = 16'd3; pa[1] = 16'd4; pw[1] = 16'd5; pa[2] = 16'hFFFF; pw[2] = 16'd7;
    run_job(3, 24'd10, 0, 5, -1);
    check("hold_res", 32'(res_data), 32'd29);

    // Reset in the middle of RUN drops the job
    for (int i = 0; i < 5; i++) begin pa[i] = 16'(i + 1); pw[i] = 16'd9; end
    run_job(5, 24'd77, 0, 0, 2);
    check("after_rst_res", 32'(res_data), 0);

`ifdef MAC_ZERO_SKIP_EN
    // Zero operands are skipped without toggling the weight bus
    pa[0] = 16'd0; pw[0] = 16'd5; pa[1] = 16'd3; pw[1] = 16'd0; pa[2] = 16'd2; pw[2] = 16'd2;
    run_job(3, 24'd1, 0, 0, -1);
    check("zskip_res", 32'(res_data), 32'd5);
    check("zskip_cnt", 32'(skip_cnt), 32'd2);
`endif

    // Randomized jobs
    for (int j = 0; j < 30; j++) begin
      int n;
      n = $urandom_range(0, 12);
      for (int i = 0; i < n; i++) begin
        pa[i] = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
        pw[i] = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
      end
      run_job(n, 24'($urandom), 2, $urandom_range(0, 3), -1);
    end

    step();
    check_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mac_dot_sequencer.md
# mac_dot_sequencer

Sequencer for one 16x16+24 bit-parallel MAC PE with a registered, saturating 24-bit output. It accepts a dot-product job (length, bias) and streams activation/weight pairs into the MAC. It recirculates the MAC output as the addend, so the MAC accumulates, then presents the final saturated sum on a valid/ready result port. The MAC instance sits beside this block in the PE and shares its clock and reset.

## Interface
- LEN_W, 16, width of job length and remaining-pair counter
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  job request; sampled only in IDLE
- len  in  LEN_W  number of pairs in the job (0 allowed)
- bias  in  24  signed initial accumulator value
- busy  out  1  high whenever state != IDLE
- op_valid  in  1  operand pair valid
- op_ready  out  1  high only in RUN
- op_a  in  16  signed activation
- op_w  in  16  signed weight
- mac_a  out  16  MAC A input (combinational)
- mac_w  out  16  MAC W input (combinational)
- mac_t  out  24  MAC T input (combinational)
- mac_y  in  24  MAC registered output Y_Q
- res_valid  out  1  result valid
- res_ready  in  1  result accepted
- res_data  out  24  signed final sum (registered)
- skip_cnt  out  LEN_W  zero-product count; present only with MAC_ZERO_SKIP_EN

## Operation
- States: IDLE, LOAD, RUN, WAIT, DONE.
- IDLE: mac_a=0, mac_w=0, mac_t=mac_y. If start=1, latch len into rem and bias, then go to LOAD.
- LOAD: mac_a=0, mac_w=0, mac_t=bias. The MAC takes bias. Go to RUN if rem!=0, else go to WAIT.
- RUN: op_ready=1. fire = op_valid & op_ready.
  - On fire: mac_a=op_a, mac_w=op_w, mac_t=mac_y, and rem decrements. If rem==1, go to WAIT.
  - On no fire (bubble): mac_a=0, mac_w=0, mac_t=mac_y, so the accumulator holds.
- WAIT: one cycle with a bubble drive. At the end of the cycle, res_data <= mac_y. Go to DONE.
- DONE: res_valid=1 with bubble drive. On res_ready=1, go to IDLE.
- start is ignored outside IDLE.
- Arithmetic: the controller never widens or saturates. Saturation happens per step inside the MAC, so the result is path-dependent (clip at each accumulate).

## Timing
- Reset: state=IDLE, rem=0, res_data=0, skip_cnt=0. Outputs: res_valid=0, op_ready=0, busy=0, mac_a=0, mac_w=0, mac_t=0 (mac_y is 0 under reset).
- start sampled at edge 0. LOAD is cycle 1. RUN begins at cycle 2.
- With back-to-back pairs, the last fire is at cycle 1+len and WAIT at cycle 2+len. res_valid rises at cycle 3+len.
- len=0: res_valid rises at cycle 3 with res_data=bias.
- Each bubble adds one cycle.
- res_valid and res_data hold stable under res_ready=0.
- rst_n low mid-job: immediate return to IDLE, the job is lost, and no result is issued.

## Configuration
- MAC_ZERO_SKIP_EN defined (operand isolation for power):
  - A fire with op_a==0 or op_w==0 drives mac_a=0.
  - On that fire, mac_w holds the last weight driven on a non-zero fire, rather than toggling.
  - Bubbles drive mac_w the same held weight.
  - skip_cnt increments on each such fire. It clears on a LOAD entry.
- MAC_ZERO_SKIP_EN undefined:
  - mac_a and mac_w pass op_a and op_w directly on fire.
  - Bubbles drive 0 on both.
  - The skip_cnt port and its logic are absent.
- Numerical results are identical either way.

## Structure
- Package mac_seq_pkg holds:
  - the state enum (IDLE, LOAD, RUN, WAIT, DONE)
  - widths: ACT_W=16, ACC_W=24, default LEN_W
- No sub-module. The MAC is instantiated by the parent PE.

## Test plan
- Basic accumulation: len=3, bias=10, pairs (2,3), (4,5), (-1,7), no bubbles -> res_data=29, res_valid at cycle 6.
- Empty job: len=0, bias=-5 -> res_data=-5 (0xFFFFFB), res_valid at cycle 3, op_ready never high.
- Bubbles: basic accumulation job with op_valid low on alternate cycles -> res_data=29, res_valid delayed by 2 cycles, mac_y constant across bubbles.
- Saturation: bias=8388600, pairs (100,100), (-1,1) -> res_data=8388606 (clip to 8388607, then -1).
- Backpressure and reset:
  - Hold res_ready=0 for 5 cycles and pulse start -> res_valid and res_data stable, start ignored, busy=1.
  - Assert rst_n low mid-RUN -> all outputs 0, state IDLE.
- Zero-skip (MAC_ZERO_SKIP_EN): bias=1, pairs (0,5), (3,0), (2,2) -> res_data=5, skip_cnt=2, mac_w never toggles on the skipped fires.
